alu_ej_1: RTL and testbench
===========================

// Module: alu_ej_1
// PURPOSE
//   4-bit, 8-function ALU (arithmetic + logic) with carry-in, registered result.
//   3-bit select H picks the operation; Cin adds to arithmetic results.
//   Leaf block of the exercise datapath; drives the result register F.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (A, B, F).
// PORTS
//   clk   in   1      single system clock; all state updates on rising edge
//   rst   in   1      synchronous, active-high reset
//   A     in   WIDTH  operand A
//   B     in   WIDTH  operand B
//   H     in   3      operation select
//   Cin   in   1      carry-in; used by arithmetic ops (H[2]=0) only
//   F     out  WIDTH  registered result
//   Cout  out  1      registered carry-out, arithmetic ops only
//   Zero  out  1      registered flag, 1 when F==0
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. rst=1 at a rising edge
//     -> F=0, Cout=0, Zero=1 on that edge; rst takes priority over any op.
//   - Otherwise every rising edge registers the combinational result of the
//     current A, B, H, Cin. Latency 1 cycle, throughput 1 op/cycle.
//   - No handshake, no FSM; inputs sampled every edge.
//   - Op table (sum is WIDTH+1 bits; F = low WIDTH bits, Cout = MSB):
//       000  A + Cin                (transfer / increment)
//       001  A + B + Cin
//       010  A + ~B + Cin           (Cin=1 -> A-B)
//       011  A + {WIDTH{1}} + Cin   (Cin=0 -> A-1; Cin=1 -> A)
//       100  A & B
//       101  A | B
//       110  A ^ B
//       111  ~A
//   - Logic ops (H[2]=1): Cin ignored, Cout=0.
//   - Arithmetic wraps modulo 2^WIDTH; no overflow flag.
//   - Zero is computed from the value being loaded into F, so it always
//     matches F in the same cycle.
//   - Reset mid-stream: the result of the op sampled on the reset edge is
//     discarded; normal operation resumes on the next edge.
//   - X/Z on inputs propagates to outputs; no masking required.
// TESTING
//   (A=0001, B=0010 throughout unless noted; check F one edge after inputs applied)
//   - rst=1 for 1 edge -> F=0000, Cout=0, Zero=1; hold rst and change inputs
//     -> outputs remain at reset values.
//   - H=000: Cin=0 -> F=0001; Cin=1 -> F=0010.
//     H=001: Cin=0 -> F=0011; Cin=1 -> F=0100.
//   - H=010: Cin=0 -> F=1110, Cout=0; Cin=1 -> F=1111, Cout=0.
//     H=011: Cin=0 -> F=0000, Cout=1, Zero=1; Cin=1 -> F=0001, Cout=1.
//   - Logic: H=100 -> 0000 (Zero=1); H=101 -> 0011; H=110 -> 0011;
//     H=111 -> 1110. Cout=0 for each, with Cin=0 and Cin=1.
//   - Wrap: A=1111, B=0001, H=001, Cin=1 -> F=0001, Cout=1.
//   - Back-to-back: change H every cycle, then assert rst during a stream;
//     F must track with exactly 1-cycle latency, and the reset-edge op is lost.

Source files
------------

// File: rtl/alu_ej_1_if.sv
// Operand/result bundle for the exercise ALU: operands and select flow in,
// registered result and flags flow back out.
interface alu_ej_1_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       H;
    logic             Cin;
    logic [WIDTH-1:0] F;
    logic             Cout;
    logic             Zero;

    modport master (
        output A, B, H, Cin,
        input  F, Cout, Zero
    );

    modport slave (
        input  A, B, H, Cin,
        output F, Cout, Zero
    );
endinterface

// File: rtl/alu_ej_1.sv
// 8-function ALU with carry-in; result, carry-out and zero flag are registered
// one cycle after the operands are sampled.
module alu_ej_1 #(
    parameter int WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    alu_ej_1_if.slave bus
);

    // Returns {carry, result}; logic ops force the carry bit to 0.
    function automatic logic [WIDTH:0] alu_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       h,
        input logic             cin
    );
        logic [WIDTH:0] cin_ext;
        logic [WIDTH:0] res;
        cin_ext = {{WIDTH{1'b0}}, cin};
        res     = '0;
        case (h)
            3'b000: res = {1'b0, a} + cin_ext;
            3'b001: res = {1'b0, a} + {1'b0, b} + cin_ext;
            3'b010: res = {1'b0, a} + {1'b0, ~b} + cin_ext;
            3'b011: res = {1'b0, a} + {1'b0, {WIDTH{1'b1}}} + cin_ext;
            3'b100: res = {1'b0, a & b};
            3'b101: res = {1'b0, a | b};
            3'b110: res = {1'b0, a ^ b};
            3'b111: res = {1'b0, ~a};
        endcase
        return res;
    endfunction

    logic [WIDTH:0]   res_p0;
    logic [WIDTH-1:0] f_p1;
    logic             cout_p1;
    logic             zero_p1;

    assign res_p0 = alu_op(bus.A, bus.B, bus.H, bus.Cin);

    // p0 -> p1: zero flag derived from the value being loaded so it tracks F
    always_ff @(posedge clk) begin
        if (rst) begin
            f_p1    <= '0;
            cout_p1 <= 1'b0;
            zero_p1 <= 1'b1;
        end else begin
            f_p1    <= res_p0[WIDTH-1:0];
            cout_p1 <= res_p0[WIDTH];
            zero_p1 <= (res_p0[WIDTH-1:0] == '0);
        end
    end

    assign bus.F    = f_p1;
    assign bus.Cout = cout_p1;
    assign bus.Zero = zero_p1;

endmodule

// File: tb/tb_alu_ej_1.sv
// Scoreboard bench for alu_ej_1: expected {F,Cout,Zero} queued at drive time,
// popped and compared one edge later.
module tb_alu_ej_1;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] exp_q[$];

    alu_ej_1_if #(.WIDTH(WIDTH)) bus ();

    alu_ej_1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got F/Cout/Zero=%b/%b/%b want %b/%b/%b",
                     tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Reference: plain integer arithmetic on the op table.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] h, input logic c);
        int s;
        logic [3:0] f;
        logic co;
        s  = 0;
        co = 1'b0;
        case (h)
            3'd0: s = int'(a) + int'(c);
            3'd1: s = int'(a) + int'(b) + int'(c);
            3'd2: s = int'(a) + (15 - int'(b)) + int'(c);
            3'd3: s = int'(a) + 15 + int'(c);
            3'd4: s = int'(a & b);
            3'd5: s = int'(a | b);
            3'd6: s = int'(a ^ b);
            default: s = int'(~a);
        endcase
        f = s[3:0];
        if (h[2] == 1'b0) co = (s > 15);
        return {f, co, (f == 4'd0)};
    endfunction

    task automatic step(input string tag, input logic r, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] h, input logic c);
        @(negedge clk);
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.H   = h;
        bus.Cin = c;
        exp_q.push_back(r ? 6'b0000_01 : model(a, b, h, c));
        @(posedge clk);
        #1;
        chk(tag, {bus.F, bus.Cout, bus.Zero}, exp_q.pop_front());
    endtask

    initial begin
        rst     = 1'b0;
        bus.A   = '0;
        bus.B   = '0;
        bus.H   = '0;
        bus.Cin = 1'b0;

        step("reset",      1'b1, 4'b0001, 4'b0010, 3'b001, 1'b0);
        step("reset_hold", 1'b1, 4'b0111, 4'b0110, 3'b101, 1'b1);

        // Fixed vectors with A=0001, B=0010
        for (int h = 0; h < 8; h++) begin
            for (int c = 0; c < 2; c++) begin
                step($sformatf("op%0d_cin%0d", h, c), 1'b0, 4'b0001, 4'b0010, 3'(h), 1'(c));
            end
        end

        // Explicit expectations from the op table
        step("inc", 1'b0, 4'b0001, 4'b0010, 3'b000, 1'b1);
        chk("inc_abs", {bus.F, bus.Cout, bus.Zero}, 6'b0010_0_0);
        step("dec_to_zero", 1'b0, 4'b0001, 4'b0010, 3'b011, 1'b0);
        chk("dec_abs", {bus.F, bus.Cout, bus.Zero}, 6'b0000_1_1);
        step("sub", 1'b0, 4'b0001, 4'b0010, 3'b010, 1'b1);
        chk("sub_abs", {bus.F, bus.Cout, bus.Zero}, 6'b1111_0_0);
        step("not", 1'b0, 4'b0001, 4'b0010, 3'b111, 1'b1);
        chk("not_abs", {bus.F, bus.Cout, bus.Zero}, 6'b1110_0_0);
        step("wrap", 1'b0, 4'b1111, 4'b0001, 3'b001, 1'b1);
        chk("wrap_abs", {bus.F, bus.Cout, bus.Zero}, 6'b0001_1_0);

        // Back-to-back stream with reset in the middle
        step("b2b0", 1'b0, 4'b0101, 4'b0011, 3'b001, 1'b0);
        step("b2b1", 1'b0, 4'b0101, 4'b0011, 3'b110, 1'b0);
        step("b2b2", 1'b1, 4'b1001, 4'b0011, 3'b101, 1'b0);
        step("b2b3", 1'b0, 4'b1001, 4'b0011, 3'b010, 1'b1);
        step("b2b4", 1'b0, 4'b1000, 4'b1000, 3'b001, 1'b0);
        chk("b2b4_abs", {bus.F, bus.Cout, bus.Zero}, 6'b0000_1_1);

        // Random stream, occasional reset
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom),
                 3'($urandom), 1'($urandom));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
